// File: rtl/cpu6502_pkg.sv
// rtl/cpu6502_pkg.sv - shared 6502 core types: stack op codes, stack sequencer states, stack page
package cpu6502_pkg;

    typedef enum logic [1:0] {
        OP_PUSH1 = 2'd0,
        OP_PUSH2 = 2'd1,
        OP_POP1  = 2'd2,
        OP_POP2  = 2'd3
    } stack_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_DEC  = 3'd2,
        ST_INC  = 3'd3,
        ST_RD   = 3'd4,
        ST_DONE = 3'd5
    } stack_seq_state_e;

    localparam logic [7:0] STACK_PAGE_DEF = 8'h01;

    function automatic logic op_is_push(input stack_op_e op);
        return (op == OP_PUSH1) || (op == OP_PUSH2);
    endfunction

    function automatic logic op_is_double(input stack_op_e op);
        return (op == OP_PUSH2) || (op == OP_POP2);
    endfunction

endpackage

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - 6502 stack access sequencer; optional sticky wrap flag under STACK_SEQ_WRAP_CHK_EN
// Turns push/pop requests into ordered page-1 memory cycles and SP dec/inc strobes.
module stack_seq
    import cpu6502_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF,
    parameter int         ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [15:0]       req_data,
    input  logic [7:0]        sp_in,
    output logic              sp_dec,
    output logic              sp_inc,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic              err
);

    stack_seq_state_e state_q;
    stack_op_e        op_q;
    stack_op_e        req_op_e;
    logic [1:0]       rem_q;
    logic [15:0]      data_q;
    logic             rd_second;
    logic [15:0]      rd_word;

    assign req_op_e = stack_op_e'(req_op);

    // sp_in moves on the DEC/INC edge, so the address must follow it live rather than be registered
    assign mem_addr = mem_valid ? ADDR_W'({STACK_PAGE, sp_in}) : '0;

    // Second byte of a POP2 lands in the high half; every first byte lands in the low half
    assign rd_second = (op_q == OP_POP2) && (rem_q == 2'd1);
    assign rd_word   = rd_second ? {mem_rdata, data_q[7:0]} : {data_q[15:8], mem_rdata};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_PUSH1;
            rem_q     <= 2'd0;
            data_q    <= 16'h0000;
            req_ready <= 1'b1;
            sp_dec    <= 1'b0;
            sp_inc    <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op_e;
                        rem_q     <= op_is_double(req_op_e) ? 2'd2 : 2'd1;
                        data_q    <= op_is_push(req_op_e) ? req_data : 16'h0000;
                        req_ready <= 1'b0;
                        if (op_is_push(req_op_e)) begin
                            state_q   <= ST_WR;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= (req_op_e == OP_PUSH2) ? req_data[15:8] : req_data[7:0];
                        end else begin
                            state_q <= ST_INC;
                            sp_inc  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ready) begin
                        state_q   <= ST_DEC;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        sp_dec    <= 1'b1;
                        rem_q     <= rem_q - 2'd1;
                    end
                end
                ST_DEC: begin
                    sp_dec <= 1'b0;
                    if (rem_q != 2'd0) begin
                        // Only PUSH2 comes back here, and its second byte is always the low one
                        state_q   <= ST_WR;
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= data_q[7:0];
                    end else begin
                        state_q   <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 16'h0000;
                    end
                end
                ST_INC: begin
                    sp_inc    <= 1'b0;
                    state_q   <= ST_RD;
                    mem_valid <= 1'b1;
                    mem_we    <= 1'b0;
                end
                ST_RD: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        data_q    <= rd_word;
                        rem_q     <= rem_q - 2'd1;
                        if (rem_q > 2'd1) begin
                            state_q <= ST_INC;
                            sp_inc  <= 1'b1;
                        end else begin
                            state_q   <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rd_word;
                        end
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_data  <= 16'h0000;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    sp_dec    <= 1'b0;
                    sp_inc    <= 1'b0;
                    mem_valid <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef STACK_SEQ_WRAP_CHK_EN
    logic err_q;

    // Sticky: a write at SP 00 or an increment from FF means the stack wrapped inside page 1
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else if (((state_q == ST_WR) && mem_ready && (sp_in == 8'h00)) ||
                     ((state_q == ST_INC) && (sp_in == 8'hFF))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - directed self-checking bench for stack_seq with SP register and page-1 memory models
module tb_stack_seq;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic [7:0]  sp_in;
    logic        sp_dec;
    logic        sp_inc;
    logic        mem_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef STACK_SEQ_WRAP_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    stack_seq dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .sp_in     (sp_in),
        .sp_dec    (sp_dec),
        .sp_inc    (sp_inc),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SP register model and page-1 memory model
    logic       sp_load;
    logic [7:0] sp_load_val;
    logic [7:0] sp;
    logic       mem_init;
    logic [7:0] mem [256];
    logic [15:0] last_wr_addr = 16'h0000;
    logic [7:0]  last_wr_data = 8'h00;
    logic [15:0] last_rsp = 16'h0000;
    int dec_cnt = 0;
    int inc_cnt = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int viol_cnt = 0;

    assign sp_in     = sp;
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (sp_load)     sp <= sp_load_val;
        else if (sp_dec) sp <= sp - 8'd1;
        else if (sp_inc) sp <= sp + 8'd1;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        end else if (clr) begin
            if (mem_valid && mem_ready && mem_we) begin
                mem[mem_addr[7:0]] = mem_wdata;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (sp_dec) dec_cnt++;
            if (sp_inc) inc_cnt++;
            if (req_valid && req_ready) acc_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = rsp_data;
            end
            if ((sp_dec && sp_inc) || ((sp_dec || sp_inc) && mem_valid) ||
                (req_ready && (mem_valid || rsp_valid)))
                viol_cnt++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
        int n;
        req_op    = op;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        step;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step;
            lat++;
        end
        rd = rsp_data;
        step;
    endtask

    int          lat;
    logic [15:0] rd;
    int          d0;
    int          i0;
    int          a0;
    int          r0;
    logic [7:0]  sp0;

    initial begin
        clr = 1'b0;
        req_valid = 1'b0;
        req_op = 2'd0;
        req_data = 16'h0000;
        mem_ready = 1'b1;
        sp_load = 1'b1;
        sp_load_val = 8'hFA;
        mem_init = 1'b1;
        step;
        step;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_sp_dec", sp_dec, 0);
        chk("rst_sp_inc", sp_inc, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        clr = 1'b1;
        sp_load = 1'b0;
        mem_init = 1'b0;
        step;

        // 1: PUSH2 1234 from SP FA, cycle by cycle
        d0 = dec_cnt;
        req_op = 2'd1;
        req_data = 16'h1234;
        req_valid = 1'b1;
        chk("p2_ready", req_ready, 1);
        step;
        req_valid = 1'b0;
        chk("p2_t1_valid", mem_valid, 1);
        chk("p2_t1_we", mem_we, 1);
        chk("p2_t1_addr", mem_addr, 16'h01FA);
        chk("p2_t1_wdata", mem_wdata, 8'h12);
        step;
        chk("p2_t2_dec", sp_dec, 1);
        chk("p2_t2_valid", mem_valid, 0);
        step;
        chk("p2_t3_addr", mem_addr, 16'h01F9);
        chk("p2_t3_wdata", mem_wdata, 8'h34);
        step;
        chk("p2_t4_dec", sp_dec, 1);
        step;
        chk("p2_t5_rsp", rsp_valid, 1);
        chk("p2_t5_data", rsp_data, 0);
        step;
        chk("p2_sp", sp, 8'hF8);
        chk("p2_mem_fa", mem[8'hFA], 8'h12);
        chk("p2_mem_f9", mem[8'hF9], 8'h34);
        chk("p2_decs", dec_cnt - d0, 2);

        // 2: POP2 brings 1234 back
        i0 = inc_cnt;
        do_req(2'd3, 16'h0000, lat, rd);
        chk("pop2_lat", lat, 5);
        chk("pop2_data", rd, 16'h1234);
        chk("pop2_sp", sp, 8'hFA);
        chk("pop2_incs", inc_cnt - i0, 2);

        // 3: PUSH1 A5 with three stall cycles
        d0 = dec_cnt;
        mem_ready = 1'b0;
        req_op = 2'd0;
        req_data = 16'h00A5;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("p1s_valid", mem_valid, 1);
            chk("p1s_addr", mem_addr, 16'h01FA);
            chk("p1s_wdata", mem_wdata, 8'hA5);
            chk("p1s_nodec", sp_dec, 0);
            if (k == 3) mem_ready = 1'b1;
            step;
        end
        chk("p1s_t5_dec", sp_dec, 1);
        chk("p1s_t5_valid", mem_valid, 0);
        step;
        chk("p1s_t6_rsp", rsp_valid, 1);
        step;
        chk("p1s_sp", sp, 8'hF9);
        chk("p1s_mem", mem[8'hFA], 8'hA5);
        chk("p1s_decs", dec_cnt - d0, 1);

        // 4: async reset in the middle of a PUSH2 write
        req_op = 2'd1;
        req_data = 16'hBEEF;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        chk("clr_pre_valid", mem_valid, 1);
        d0 = dec_cnt;
        #2 clr = 1'b0;
        #1;
        chk("clr_valid", mem_valid, 0);
        chk("clr_we", mem_we, 0);
        chk("clr_addr", mem_addr, 0);
        chk("clr_wdata", mem_wdata, 0);
        chk("clr_ready", req_ready, 1);
        step;
        step;
        clr = 1'b1;
        mem_ready = 1'b1;
        step;
        step;
        chk("clr_nodec", dec_cnt - d0, 0);
        chk("clr_after_ready", req_ready, 1);
        chk("clr_sp", sp, 8'hF9);
        do_req(2'd2, 16'h0000, lat, rd);
        chk("clr_pop1_lat", lat, 3);
        chk("clr_pop1_data", rd, 16'h00A5);
        chk("clr_pop1_sp", sp, 8'hFA);

        // 5: push at SP 00 wraps to FF; err only with the wrap check built in
        sp_load = 1'b1;
        sp_load_val = 8'h00;
        step;
        sp_load = 1'b0;
        do_req(2'd0, 16'h005A, lat, rd);
        chk("wrap_lat", lat, 3);
        chk("wrap_addr", last_wr_addr, 16'h0100);
        chk("wrap_data", last_wr_data, 8'h5A);
        chk("wrap_sp", sp, 8'hFF);
        chk("wrap_err", err, EXP_ERR);
        sp_load = 1'b1;
        sp_load_val = 8'h80;
        step;
        sp_load = 1'b0;
        do_req(2'd0, 16'h0011, lat, rd);
        chk("wrap_err_sticky", err, EXP_ERR);
        chk("wrap_sp2", sp, 8'h7F);

        // 6: req_valid held high across back-to-back POP1s
        sp0 = sp;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        req_op = 2'd2;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) step;
        req_valid = 1'b0;
        chk("hold_accepts", acc_cnt - a0, 2);
        chk("hold_rsps", rsp_cnt - r0, 2);
        chk("hold_sp", sp, sp0 + 8'd2);
        chk("hold_last_rsp", last_rsp, 16'h00DB);
        step;
        step;
        chk("overlap_viol", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
Stack access sequencer for the 6502 core. Turns single- and double-byte push/pop requests (PHA/PLA, JSR/RTS return address, interrupt PC) into ordered memory cycles in page 0x01. Drives the dec/inc strobes of the CPU stack pointer register and reads that register's value back. Sits between the control unit (request side) and the memory bus interface (memory side).

Parameters:
STACK_PAGE, 8'h01, high address byte for all stack accesses
ADDR_W, 16, memory address width

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  reset, asynchronous, active-low
req_valid  input  1  request offered
req_ready  output  1  sequencer can accept; high only in IDLE
req_op  input  2  0=PUSH1, 1=PUSH2, 2=POP1, 3=POP2
req_data  input  16  push data; PUSH1 uses [7:0]; PUSH2 writes [15:8] first
sp_in  input  8  current stack pointer value
sp_dec  output  1  one-cycle decrement strobe to stack pointer
sp_inc  output  1  one-cycle increment strobe to stack pointer
mem_valid  output  1  memory cycle requested
mem_we  output  1  1=write, 0=read; valid with mem_valid
mem_addr  output  ADDR_W  {STACK_PAGE, sp_in}
mem_wdata  output  8  write byte
mem_ready  input  1  memory accepts/completes cycle
mem_rdata  input  8  read byte; valid when mem_valid&mem_ready&!mem_we
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  16  pop result; POP1 in [7:0], [15:8]=0; 0 for pushes
err  output  1  stack wrap flag (see Optional Feature)

Behaviour:
- Reset (clr low, async): state IDLE; req_ready=1; sp_dec, sp_inc, mem_valid, mem_we, rsp_valid, err=0; mem_addr, mem_wdata, rsp_data=0. Any in-flight memory cycle is abandoned; no strobe is issued after reset.
- States: IDLE, WR, DEC, INC, RD, DONE. Byte counter rem (1 or 2) and 16-bit data latch.
- IDLE: on req_valid&req_ready latch op/data, rem = 2 for PUSH2/POP2, else 1. Go to WR for a push and INC for a pop.
- WR: mem_valid=1, mem_we=1, mem_addr={STACK_PAGE,sp_in}, mem_wdata = data[15:8] when the op is PUSH2 and rem=2, else data[7:0]. Hold all outputs stable until mem_ready. On handshake go to DEC, rem-1.
- DEC: sp_dec=1 for exactly one cycle. The SP updates on this edge. Next state is WR if rem>0, else DONE.
- INC: sp_inc=1 for exactly one cycle, then RD. RD therefore sees the incremented sp_in.
- RD: mem_valid=1, mem_we=0, address as in WR. On handshake capture mem_rdata: the first byte goes to [7:0], the second byte goes to [15:8]. rem-1. Next state is INC if rem>0, else DONE.
- DONE: rsp_valid=1 for one cycle with rsp_data, then IDLE. No response backpressure.
- sp_dec and sp_inc are never high together. Neither strobe is ever asserted in the same cycle as mem_valid.
- Latency with mem_ready tied high:
  - PUSH1: accept T0, rsp T3.
  - PUSH2: accept T0, rsp T5.
  - POP1: accept T0, rsp T3.
  - POP2: accept T0, rsp T5.
  - Each mem_ready stall cycle adds one cycle.
- req_valid while busy is ignored, because req_ready=0. A request is accepted on the same cycle DONE→IDLE occurs only once the block is in IDLE. The first new acceptance is the cycle after DONE.
- SP arithmetic is 8-bit modulo; 0x00-1 = 0xFF and 0xFF+1 = 0x00. The address is always in STACK_PAGE.

Optional Feature:
STACK_SEQ_WRAP_CHK_EN defined:
- err is sticky. It is set when a WR handshake occurs with sp_in==8'h00, or an INC occurs with sp_in==8'hFF.
- err is cleared only by reset.
- The sequence still completes and wraps.

Not defined: err tied 0; no detection logic.

Decomposition:
- Shared package cpu6502_pkg holds:
  - stack op enum (PUSH1/PUSH2/POP1/POP2)
  - sequencer state enum
  - STACK_PAGE default
- No sub-module. Single FSM plus data latch.

Test Plan:
The bench models the SP register as 8-bit, reset 8'hFA, with dec/inc applied on the clock edge.
1. PUSH2 data 16'h1234, SP=FA, mem_ready=1 → writes 0x01FA←12 then 0x01F9←34; two sp_dec pulses; SP ends F8; rsp_valid at T5.
2. Then POP2 → sp_inc, read 0x01F9 (34), sp_inc, read 0x01FA (12); rsp_data=16'h1234; SP ends FA.
3. PUSH1 data 8'hA5 with mem_ready low 3 cycles → mem_valid/addr 0x01FA/wdata A5 held stable 4 cycles; single sp_dec after handshake; rsp at T6.
4. clr pulsed low during WR of PUSH2 → outputs zero immediately (async); no sp_dec; req_ready=1 after release; next POP1 runs normally.
5. With STACK_SEQ_WRAP_CHK_EN, SP=00, PUSH1 → write 0x0100, SP→FF, err=1 and stays set. Without the macro, err=0.
6. req_valid held high during a POP1 → second request accepted only after DONE; no overlap of memory cycles.
